shared_cmp_alu: RTL and testbench

SHARED_CMP_ALU -- requirements
Module: shared_cmp_alu

---
 rtl/shared_cmp_alu_pkg.sv | 14 +
 rtl/shared_cmp_alu_rr_arbiter.sv | 58 +++++
 rtl/shared_cmp_alu.sv | 153 +++++++++++++++
 tb/tb_shared_cmp_alu.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_cmp_alu_pkg.sv
// Shared definitions for the shared compare/arithmetic pipeline.
// Holds the mode encoding and the channel-index width helper.
// No logic; imported by the arbiter and the top.
package shared_cmp_alu_pkg;

    localparam logic MODE_CMPADD  = 1'b0;
    localparam logic MODE_EQSHIFT = 1'b1;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_cmp_alu_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after the pointer.
// Latency: combinational grant; pointer moves on the edge where adv_i is high.
// Backpressure: the pointer holds whenever adv_i is low, so a stalled grant is re-offered.
module rr_arbiter
    import shared_cmp_alu_pkg::*;
#(
    parameter int NCH = 2,
    localparam int CW = ch_w(NCH)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [NCH-1:0] req_i,
    input  logic           adv_i,
    output logic [NCH-1:0] gnt_o,
    output logic           gnt_vld_o,
    output logic [CW-1:0]  gnt_idx_o
);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    int            j;

    // Circular search from the pointer for the first active request.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        j         = 0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!gnt_vld_o && req_i[j]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = CW'(j);
            end
        end
        gnt_o = gnt_vld_o ? (NCH'(1) << gnt_idx_o) : '0;
    end

    // Next pointer: one past the accepted channel, wrapping at NCH.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (gnt_idx_o == CW'(NCH - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shared_cmp_alu.sv
// Multi-channel compare-then-add/sub or equal-then-shift unit sharing one comparator and one adder.
// Latency: 2 cycles from accept to OUT_VALID; one accept per cycle when the output is not stalled.
// Backpressure: S2 holds while stalled, S1 moves only into an empty S2, IN_READY drops when S1 is stuck.
module shared_cmp_alu
    import shared_cmp_alu_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int NCH   = 2,
    parameter int INC   = 2,
    parameter int SH    = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NCH-1:0]         IN_VALID,
    output logic [NCH-1:0]         IN_READY,
    input  logic [NCH-1:0]         IN_MODE,
    input  logic [NCH*WIDTH-1:0]   IN1,
    input  logic [NCH*WIDTH-1:0]   IN2,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [ch_w(NCH)-1:0]   OUT_CH,
    output logic [WIDTH-1:0]       OUT_DATA,
    output logic                   OUT_FLAG,
    output logic                   OUT_OVF
);

    localparam int CW = ch_w(NCH);

    // IN_READY stays low until the first edge after reset release.
    logic rdy_en_q;

    logic [NCH-1:0] gnt;
    logic           gnt_vld;
    logic [CW-1:0]  gnt_idx;

    logic             s2_free, s1_adv, s1_free, accept;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             mode_sel;
    logic [WIDTH:0]   cmp_diff;
    logic             cmp_lt, cmp_eq;

    logic             s1_vld_q, s1_vld_d;
    logic [CW-1:0]    s1_ch_q;
    logic             s1_mode_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             s1_cmp_q, s1_cmp_d;

    logic             sub;
    logic [WIDTH-1:0] inc_v;
    logic [WIDTH:0]   addsub;
    logic [WIDTH+SH-1:0] shl_full;

    logic             s2_vld_q, s2_vld_d;
    logic [CW-1:0]    s2_ch_q;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic             s2_flag_q, s2_ovf_q, s2_ovf_d;

    assign s2_free  = !s2_vld_q || OUT_READY;
    assign s1_adv   = s1_vld_q && s2_free;
    assign s1_free  = !s1_vld_q || s1_adv;
    assign accept   = rdy_en_q && s1_free && gnt_vld;
    assign IN_READY = (rdy_en_q && s1_free) ? gnt : '0;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .req_i     (IN_VALID),
        .adv_i     (accept),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // Single shared comparator on the granted channel's operands: borrow gives A<B, zero gives A==B.
    always_comb begin
        a_sel    = IN1[gnt_idx*WIDTH +: WIDTH];
        b_sel    = IN2[gnt_idx*WIDTH +: WIDTH];
        mode_sel = IN_MODE[gnt_idx];
        cmp_diff = {1'b0, a_sel} - {1'b0, b_sel};
        cmp_lt   = cmp_diff[WIDTH];
        cmp_eq   = (cmp_diff[WIDTH-1:0] == '0);
        s1_cmp_d = (mode_sel == MODE_EQSHIFT) ? cmp_eq : cmp_lt;
        s1_vld_d = accept || (s1_vld_q && !s1_adv);
    end

    // S1: capture the accepted request and its compare outcome.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdy_en_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_ch_q   <= '0;
            s1_mode_q <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_cmp_q  <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            s1_vld_q <= s1_vld_d;
            if (accept) begin
                s1_ch_q   <= gnt_idx;
                s1_mode_q <= mode_sel;
                s1_a_q    <= a_sel;
                s1_b_q    <= b_sel;
                s1_cmp_q  <= s1_cmp_d;
            end
        end
    end

    // Single shared adder: subtract is A + ~INC + 1, so its carry-out is the inverse of the borrow.
    always_comb begin
        sub      = (s1_mode_q == MODE_CMPADD) && !s1_cmp_q;
        inc_v    = WIDTH'(INC);
        addsub   = {1'b0, s1_a_q} + {1'b0, (sub ? ~inc_v : inc_v)} + {{WIDTH{1'b0}}, sub};
        shl_full = {{SH{1'b0}}, s1_b_q} << SH;
        if (s1_mode_q == MODE_CMPADD) begin
            s2_data_d = addsub[WIDTH-1:0];
            s2_ovf_d  = sub ? !addsub[WIDTH] : addsub[WIDTH];
        end else if (s1_cmp_q) begin
            s2_data_d = shl_full[WIDTH-1:0];
            s2_ovf_d  = |shl_full[WIDTH+SH-1:WIDTH];
        end else begin
            s2_data_d = s1_b_q >> SH;
            s2_ovf_d  = 1'b0;
        end
        s2_vld_d = s1_adv || (s2_vld_q && !OUT_READY);
    end

    // S2: output register, loaded only when S1 advances so it holds while stalled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_vld_q  <= 1'b0;
            s2_ch_q   <= '0;
            s2_data_q <= '0;
            s2_flag_q <= 1'b0;
            s2_ovf_q  <= 1'b0;
        end else begin
            s2_vld_q <= s2_vld_d;
            if (s1_adv) begin
                s2_ch_q   <= s1_ch_q;
                s2_data_q <= s2_data_d;
                s2_flag_q <= s1_cmp_q;
                s2_ovf_q  <= s2_ovf_d;
            end
        end
    end

    assign OUT_VALID = s2_vld_q;
    assign OUT_CH    = s2_ch_q;
    assign OUT_DATA  = s2_data_q;
    assign OUT_FLAG  = s2_flag_q;
    assign OUT_OVF   = s2_ovf_q;

endmodule

// File: tb/tb_shared_cmp_alu.sv
// Self-checking bench for shared_cmp_alu with a transaction-level reference model.
// Model tracks in-flight results in a queue; expected timing follows from pipeline capacity.
// Directed cases, throughput, backpressure, mid-run reset and a randomized soak.
module tb_shared_cmp_alu;

    localparam int W   = 17;
    localparam int NCH = 2;
    localparam int INC = 2;
    localparam int SH  = 2;
    localparam longint MOD = 64'd1 << W;

    logic             CLK;
    logic             RST_N;
    logic [NCH-1:0]   IN_VALID;
    logic [NCH-1:0]   IN_READY;
    logic [NCH-1:0]   IN_MODE;
    logic [NCH*W-1:0] IN1, IN2;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [0:0]       OUT_CH;
    logic [W-1:0]     OUT_DATA;
    logic             OUT_FLAG;
    logic             OUT_OVF;

    shared_cmp_alu #(.WIDTH(W), .NCH(NCH), .INC(INC), .SH(SH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_MODE(IN_MODE),
        .IN1(IN1), .IN2(IN2),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_CH(OUT_CH),
        .OUT_DATA(OUT_DATA), .OUT_FLAG(OUT_FLAG), .OUT_OVF(OUT_OVF)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int         ch;
        logic [W-1:0] data;
        logic       flag;
        logic       ovf;
        int         acc;
    } item_t;

    item_t q[$];
    int    ptr     = 0;
    int    cycle   = 0;
    int    edges   = 0;
    int    acc_cnt = 0;
    int    out_cnt = 0;

    // Reference arithmetic straight from the operation definitions.
    function automatic item_t ref_op(input int ch, input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
        item_t  it;
        longint av, bv, r;
        av = longint'(a);
        bv = longint'(b);
        it.ch = ch;
        it.acc = 0;
        if (mode == 1'b0) begin
            it.flag = (av < bv);
            if (av < bv) begin
                r = av + INC;
                it.ovf = (r >= MOD);
            end else begin
                r = av - INC;
                it.ovf = (r < 0);
            end
            if (r < 0) r = r + MOD;
            it.data = W'(r % MOD);
        end else begin
            it.flag = (av == bv);
            if (av == bv) begin
                r = bv * (64'd1 << SH);
                it.ovf = (r >= MOD);
                it.data = W'(r % MOD);
            end else begin
                it.data = W'(bv / (64'd1 << SH));
                it.ovf = 1'b0;
            end
        end
        return it;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) edges = 0;
        else if (edges < 3) edges = edges + 1;
    end

    // Monitor: sample mid-cycle, compare against the model, then advance the model.
    always @(negedge CLK) begin
        logic [NCH-1:0] exp_rdy;
        logic           exp_ov;
        int             g;
        item_t          it;
        if (!RST_N) begin
            q.delete();
            ptr = 0;
            check_val("rst_out_valid", OUT_VALID, 0);
            check_val("rst_out_data", OUT_DATA, 0);
            check_val("rst_out_ch", OUT_CH, 0);
            check_val("rst_out_flag", OUT_FLAG, 0);
            check_val("rst_out_ovf", OUT_OVF, 0);
            check_val("rst_in_ready", IN_READY, 0);
        end else begin
            cycle++;
            exp_ov = (q.size() > 0) && (cycle >= q[0].acc + 2);
            check_val("out_valid", OUT_VALID, exp_ov);
            if (OUT_VALID && q.size() > 0) begin
                check_val("out_ch", OUT_CH, q[0].ch);
                check_val("out_data", OUT_DATA, q[0].data);
                check_val("out_flag", OUT_FLAG, q[0].flag);
                check_val("out_ovf", OUT_OVF, q[0].ovf);
            end
            // Two results fit in flight; a third is taken only if one leaves this cycle.
            g = -1;
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && IN_VALID[(ptr + k) % NCH]) g = (ptr + k) % NCH;
            end
            exp_rdy = '0;
            if (edges > 0 && g >= 0 && (q.size() < 2 || OUT_READY)) exp_rdy[g] = 1'b1;
            check_val("in_ready", IN_READY, exp_rdy);
            if (OUT_VALID && OUT_READY && q.size() > 0) begin
                void'(q.pop_front());
                out_cnt++;
            end
            if (exp_rdy != '0) begin
                it = ref_op(g, IN_MODE[g], IN1[g*W +: W], IN2[g*W +: W]);
                it.acc = cycle;
                q.push_back(it);
                ptr = (g + 1) % NCH;
                acc_cnt++;
            end
        end
    end

    task automatic set_ch(input int ch, input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
        IN_MODE[ch]       = mode;
        IN1[ch*W +: W]    = a;
        IN2[ch*W +: W]    = b;
    endtask

    task automatic run_one(input string tag, input int ch, input logic mode,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ed, input logic ef, input logic eo);
        bit acc, got;
        int lat;
        @(posedge CLK); #1;
        IN_VALID     = '0;
        OUT_READY    = 1'b1;
        set_ch(ch, mode, a, b);
        IN_VALID[ch] = 1'b1;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge CLK);
            if (IN_READY[ch]) acc = 1;
        end
        check_val({tag, "_accept"}, acc, 1);
        @(posedge CLK); #1;
        IN_VALID = '0;
        got = 0;
        lat = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                got = 1;
                lat = i;
            end
        end
        check_val({tag, "_latency"}, lat, 2);
        check_val({tag, "_data"}, OUT_DATA, ed);
        check_val({tag, "_flag"}, OUT_FLAG, ef);
        check_val({tag, "_ovf"}, OUT_OVF, eo);
        check_val({tag, "_ch"}, OUT_CH, ch);
    endtask

    function automatic logic [W-1:0] pick_opnd();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0: v = '0;
            1: v = '1;
            2: v = W'($urandom_range(0, 5));
            3: v = W'(17'h10000 | $urandom_range(0, 3));
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic rand_inputs();
        logic [W-1:0] a;
        for (int c = 0; c < NCH; c++) begin
            a = pick_opnd();
            set_ch(c, 1'($urandom_range(0, 1)), a, ($urandom_range(0, 2) == 0) ? a : pick_opnd());
        end
    endtask

    task automatic drain(input string tag);
        @(posedge CLK); #1;
        IN_VALID  = '0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        #1;
        check_val({tag, "_drained"}, q.size(), 0);
    endtask

    initial begin
        int a0, o0;
        bit seen;
        RST_N     = 1'b0;
        IN_VALID  = '0;
        IN_MODE   = '0;
        IN1       = '0;
        IN2       = '0;
        OUT_READY = 1'b0;
        IN_VALID  = 2'b11;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        IN_VALID = '0;

        // Directed operation cases.
        run_one("add_lt",   0, 1'b0, 17'd5,       17'd9,       17'd7,       1'b1, 1'b0);
        run_one("sub_bor",  1, 1'b0, 17'd1,       17'd0,       17'h1FFFF,   1'b0, 1'b1);
        run_one("sub_max",  1, 1'b0, 17'h1FFFF,   17'h1FFFF,   17'h1FFFD,   1'b0, 1'b0);
        run_one("shl_eq",   0, 1'b1, 17'd3,       17'd3,       17'd12,      1'b1, 1'b0);
        run_one("shr_ne",   1, 1'b1, 17'd16,      17'd3,       17'd0,       1'b0, 1'b0);
        run_one("shl_ovf",  0, 1'b1, 17'h10000,   17'h10000,   17'd0,       1'b1, 1'b1);
        run_one("add_wrap", 0, 1'b0, 17'h1FFFE,   17'h1FFFF,   17'd0,       1'b1, 1'b1);
        drain("directed");

        // Both channels continuously valid, no backpressure: one accept and one result per cycle.
        @(posedge CLK); #1;
        rand_inputs();
        IN_VALID = 2'b11;
        a0 = acc_cnt;
        o0 = out_cnt;
        repeat (8) @(posedge CLK);
        #1;
        IN_VALID = '0;
        check_val("tput_accepts", acc_cnt - a0, 8);
        repeat (2) @(posedge CLK);
        #1;
        check_val("tput_results", out_cnt - o0, 8);
        drain("tput");

        // Output stalled for 5 cycles with both channels valid.
        @(posedge CLK); #1;
        rand_inputs();
        OUT_READY = 1'b0;
        IN_VALID  = 2'b11;
        a0 = acc_cnt;
        o0 = out_cnt;
        repeat (5) @(posedge CLK);
        #1;
        check_val("bp_accepts", acc_cnt - a0, 2);
        check_val("bp_no_output", out_cnt - o0, 0);
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        drain("bp");

        // Randomized soak.
        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK); #1;
            rand_inputs();
            IN_VALID  = NCH'($urandom_range(0, 3));
            OUT_READY = ($urandom_range(0, 9) < 7);
        end
        drain("rand");

        // Reset with two requests in flight; pointer left at 1 beforehand.
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        set_ch(0, 1'b0, 17'd5, 17'd9);
        IN_VALID = 2'b01;
        repeat (3) @(posedge CLK);
        #1;
        check_val("pre_rst_inflight", q.size(), 2);
        IN_VALID = 2'b11;
        #2;
        RST_N = 1'b0;
        #1;
        check_val("arst_out_valid", OUT_VALID, 0);
        check_val("arst_out_data", OUT_DATA, 0);
        check_val("arst_in_ready", IN_READY, 0);
        @(posedge CLK); #3;
        RST_N     = 1'b1;
        OUT_READY = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (IN_READY != '0) begin
                seen = 1;
                check_val("post_rst_first_grant", IN_READY, 2'b01);
            end
        end
        check_val("post_rst_grant_seen", seen, 1);
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
